// File: rtl/tof_edge_gen.sv
// tof_edge_gen: time-of-flight edge generator.
//
// Takes a signed target delay and produces one toggle on each of Y1 and Y2,
// spaced by |target| clock cycles. Y1 leads for a positive target and Y2
// leads for a negative one. A zero target toggles both lines on the same edge.
// The generator drives the TOF counter for self-test and loopback.
//
// Optional build macro: TOF_GEN_AUTO_EN. When it is defined, an auto_en input
// is added. If auto_en is high at the end of the gap, the same target is
// relaunched without a new tof_load.
//
// Ports:
//   clk          rising-edge clock
//   reset_L      asynchronous active-low reset
//   tof_in       signed target delay (two's complement, CW bits)
//   tof_load     launch strobe, accepted only while busy=0
//   auto_en      (TOF_GEN_AUTO_EN only) keep relaunching while high
//   Y1, Y2       registered edge outputs; each launch toggles them
//   busy         high from launch acceptance until done
//   done         one-cycle pulse at the end of the gap
//   tof_last     last accepted target
//   dbg_state_o  current FSM state (IDLE=0, LEAD=1, DELAY=2, GAP=3)
//
// Handshake: tof_load is a single-cycle request. It is taken on the rising
// edge where busy=0, and it is ignored in every other cycle. There is no
// back-pressure beyond busy.
module tof_edge_gen #(
  parameter int GAP = 4,
  parameter int CW  = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic signed [CW-1:0] tof_in,
  input  logic                 tof_load,
`ifdef TOF_GEN_AUTO_EN
  input  logic                 auto_en,
`endif
  output logic                 Y1,
  output logic                 Y2,
  output logic                 busy,
  output logic                 done,
  output logic signed [CW-1:0] tof_last,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_DELAY, S_GAP} state_t;

  localparam logic [CW-1:0] GAP_M1 = CW'(GAP - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        d_q;
  logic [CW-1:0]        mag;
  logic                 lead_y2_q;
  logic signed [CW-1:0] last_q;
  logic                 t1_q, t2_q;
  logic                 y1_q, y2_q;
  logic                 fin_q, end_q, done_q, busy_q;
  logic                 accept, tgl_lead, tgl_lag, fin, relaunch, auto_w;

`ifdef TOF_GEN_AUTO_EN
  assign auto_w = auto_en;
`else
  assign auto_w = 1'b0;
`endif

  // busy=0 already implies IDLE. The state term keeps acceptance local to the FSM.
  assign accept = tof_load && !busy_q && (state_q == S_IDLE);

  // Unsigned magnitude. -2^(CW-1) maps to 2^(CW-1) without saturation.
  assign mag = tof_in[CW-1] ? $unsigned(-tof_in) : $unsigned(tof_in);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgl_lead = 1'b0;
    tgl_lag  = 1'b0;
    fin      = 1'b0;
    relaunch = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LEAD;
      end
      S_LEAD: begin
        tgl_lead = 1'b1;
        if (d_q == '0) begin
          tgl_lag = 1'b1;
          cnt_d   = GAP_M1;
          state_d = S_GAP;
        end else begin
          cnt_d   = d_q - 1'b1;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          tgl_lag = 1'b1;
          cnt_d   = GAP_M1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          fin = 1'b1;
          if (auto_w) begin
            relaunch = 1'b1;
            state_d  = S_LEAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Toggle and finish requests pass through one register stage before they
  // reach the outputs. This puts the lead toggle two edges after acceptance.
  // done and the busy release come out through the same two-stage path, so
  // they stay aligned with the toggles.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      d_q       <= '0;
      lead_y2_q <= 1'b0;
      last_q    <= '0;
      t1_q      <= 1'b0;
      t2_q      <= 1'b0;
      y1_q      <= 1'b0;
      y2_q      <= 1'b0;
      fin_q     <= 1'b0;
      end_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        d_q       <= mag;
        lead_y2_q <= tof_in[CW-1];
        last_q    <= tof_in;
      end
      t1_q   <= (tgl_lead & ~lead_y2_q) | (tgl_lag & lead_y2_q);
      t2_q   <= (tgl_lead & lead_y2_q) | (tgl_lag & ~lead_y2_q);
      y1_q   <= y1_q ^ t1_q;
      y2_q   <= y2_q ^ t2_q;
      fin_q  <= fin;
      end_q  <= fin & ~relaunch;
      done_q <= fin_q;
      if (accept)     busy_q <= 1'b1;
      else if (end_q) busy_q <= 1'b0;
    end
  end

  assign Y1          = y1_q;
  assign Y2          = y2_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign tof_last    = last_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tof_edge_gen.sv
// Testbench for tof_edge_gen. The reference model schedules the lead, lag
// and done events as absolute cycle numbers measured from the acceptance edge.
module tb_tof_edge_gen;
  localparam int GAP = 4;
  localparam int CW  = 8;

  logic                 clk = 1'b0;
  logic                 reset_L = 1'b0;
  logic signed [CW-1:0] tof_in = '0;
  logic                 tof_load = 1'b0;
`ifdef TOF_GEN_AUTO_EN
  logic                 auto_en = 1'b0;
`endif
  logic                 Y1, Y2, busy, done;
  logic signed [CW-1:0] tof_last;
  logic [1:0]           dbg_state;

  int n_chk = 0;
  int n_err = 0;

  tof_edge_gen #(.GAP(GAP), .CW(CW)) dut (
    .clk(clk), .reset_L(reset_L), .tof_in(tof_in), .tof_load(tof_load),
`ifdef TOF_GEN_AUTO_EN
    .auto_en(auto_en),
`endif
    .Y1(Y1), .Y2(Y2), .busy(busy), .done(done), .tof_last(tof_last),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int cyc, t_acc, t_lead, t_lag, t_done, t_pulse, m_d;
  bit m_y2;
  logic exp_y1, exp_y2, exp_busy, exp_done;
  logic signed [CW-1:0] exp_last;

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cyc = 0; t_acc = 0; t_lead = -1; t_lag = -1; t_done = 0; t_pulse = -1;
      m_d = 0; m_y2 = 0;
      exp_y1 = 0; exp_y2 = 0; exp_busy = 0; exp_done = 0; exp_last = '0;
    end else begin
      cyc++;
      if (!exp_busy && tof_load) begin
        m_d      = (int'(tof_in) < 0) ? -int'(tof_in) : int'(tof_in);
        m_y2     = int'(tof_in) < 0;
        exp_last = tof_in;
        t_acc    = cyc;
        t_lead   = cyc + 2;
        t_lag    = cyc + 2 + m_d;
        t_done   = t_lag + GAP;
        t_pulse  = -1;
      end
`ifdef TOF_GEN_AUTO_EN
      else if (exp_busy && auto_en && cyc == t_done - 1) begin
        t_pulse = t_done;
        t_lead  = cyc + 2;
        t_lag   = cyc + 2 + m_d;
        t_done  = t_lag + GAP;
      end
`endif
      exp_done = (cyc == t_done) || (cyc == t_pulse);
      exp_busy = (cyc >= t_acc) && (cyc < t_done);
      if (cyc == t_lead) begin
        if (m_y2) exp_y2 = ~exp_y2; else exp_y1 = ~exp_y1;
      end
      if (cyc == t_lag) begin
        if (m_y2) exp_y1 = ~exp_y1; else exp_y2 = ~exp_y2;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0; tof_load = 1'b0;
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_L = 1'b0;
    #1;
    n_chk++;
    if ({Y1, Y2, busy, done} !== 4'b0000 || tof_last !== 8'sd0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset: Y1=%b Y2=%b busy=%b done=%b last=%0d st=%0d, want all 0",
               Y1, Y2, busy, done, tof_last, dbg_state);
    end
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_pos5();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++;
      if (Y1 !== exp_y1 || Y2 !== exp_y2 || busy !== exp_busy || done !== exp_done || tof_last !== exp_last) begin
        n_err++;
        $display("FAIL pos5 i=%0d: got %b%b b%b d%b %0d want %b%b b%b d%b %0d", i,
                 Y1, Y2, busy, done, tof_last, exp_y1, exp_y2, exp_busy, exp_done, exp_last);
      end
      tof_load = (i == 1); tof_in = 8'sd5;
    end
    n_chk++;
    if (tof_last !== 8'sd5 || Y1 !== 1'b1 || Y2 !== 1'b1) begin
      n_err++;
      $display("FAIL pos5_end: last=%0d Y1=%b Y2=%b, want 5 1 1", tof_last, Y1, Y2);
    end
  endtask

  task automatic test_neg3();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      n_chk++;
      if (Y1 !== exp_y1 || Y2 !== exp_y2 || busy !== exp_busy || done !== exp_done || tof_last !== exp_last) begin
        n_err++;
        $display("FAIL neg3 i=%0d: got %b%b b%b d%b %0d want %b%b b%b d%b %0d", i,
                 Y1, Y2, busy, done, tof_last, exp_y1, exp_y2, exp_busy, exp_done, exp_last);
      end
      tof_load = (i == 1); tof_in = -8'sd3;
    end
  endtask

  task automatic test_zero_then_one();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      n_chk++;
      if (Y1 !== exp_y1 || Y2 !== exp_y2 || busy !== exp_busy || done !== exp_done || tof_last !== exp_last) begin
        n_err++;
        $display("FAIL zero_one i=%0d: got %b%b b%b d%b %0d want %b%b b%b d%b %0d", i,
                 Y1, Y2, busy, done, tof_last, exp_y1, exp_y2, exp_busy, exp_done, exp_last);
      end
      tof_load = (i == 0) || (i == 9);
      tof_in   = (i == 0) ? 8'sd0 : 8'sd1;
    end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 290; i++) begin
      @(negedge clk);
      n_chk++;
      if (Y1 !== exp_y1 || Y2 !== exp_y2 || busy !== exp_busy || done !== exp_done || tof_last !== exp_last) begin
        n_err++;
        $display("FAIL extremes i=%0d: got %b%b b%b d%b %0d want %b%b b%b d%b %0d", i,
                 Y1, Y2, busy, done, tof_last, exp_y1, exp_y2, exp_busy, exp_done, exp_last);
      end
      tof_load = (i == 0) || (i == 145);
      tof_in   = (i < 100) ? -8'sd128 : 8'sd127;
    end
  endtask

  task automatic test_ignore_busy();
    bit took = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_chk++;
      if (Y1 !== exp_y1 || Y2 !== exp_y2 || busy !== exp_busy || done !== exp_done || tof_last !== exp_last) begin
        n_err++;
        $display("FAIL ignore i=%0d: got %b%b b%b d%b %0d want %b%b b%b d%b %0d", i,
                 Y1, Y2, busy, done, tof_last, exp_y1, exp_y2, exp_busy, exp_done, exp_last);
      end
      if (i == 15) begin
        n_chk++;
        if (tof_last !== 8'sd20) begin
          n_err++;
          $display("FAIL ignore_last: got %0d want 20", tof_last);
        end
      end
      tof_load = (i == 0) || (i == 5) || (i == 8) || (i == 12);
      tof_in   = (i == 0) ? 8'sd20 : 8'sd9;
      if (exp_done && !took) begin
        took = 1; tof_load = 1'b1; tof_in = 8'sd7;
      end
    end
    n_chk++;
    if (tof_last !== 8'sd7) begin
      n_err++;
      $display("FAIL done_cycle_load: last=%0d want 7", tof_last);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tof_load = (i == 0); tof_in = 8'sd20;
    end
    reset_L = 1'b0;
    #1;
    n_chk++;
    if ({Y1, Y2, busy, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid: Y1=%b Y2=%b busy=%b done=%b want 0000", Y1, Y2, busy, done);
    end
    @(negedge clk);
    reset_L = 1'b1; tof_load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_chk++;
      if (Y1 !== exp_y1 || Y2 !== exp_y2 || busy !== exp_busy || done !== exp_done || done !== 1'b0) begin
        n_err++;
        $display("FAIL after_reset i=%0d: got %b%b b%b d%b want %b%b b%b d0", i,
                 Y1, Y2, busy, done, exp_y1, exp_y2, exp_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      n_chk++;
      if (Y1 !== exp_y1 || Y2 !== exp_y2 || busy !== exp_busy || done !== exp_done || tof_last !== exp_last) begin
        n_err++;
        $display("FAIL random i=%0d: got %b%b b%b d%b %0d want %b%b b%b d%b %0d", i,
                 Y1, Y2, busy, done, tof_last, exp_y1, exp_y2, exp_busy, exp_done, exp_last);
      end
      tof_load = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) tof_in = CW'($urandom_range(0, 255));
      else                           tof_in = CW'(int'($urandom_range(0, 30)) - 15);
    end
    tof_load = 1'b0;
  endtask

`ifdef TOF_GEN_AUTO_EN
  task automatic test_auto();
    int n_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_chk++;
      if (Y1 !== exp_y1 || Y2 !== exp_y2 || busy !== exp_busy || done !== exp_done) begin
        n_err++;
        $display("FAIL auto i=%0d: got %b%b b%b d%b want %b%b b%b d%b", i,
                 Y1, Y2, busy, done, exp_y1, exp_y2, exp_busy, exp_done);
      end
      if (done) n_done++;
      auto_en  = (i < 35);
      tof_load = (i == 0) || (i == 10); tof_in = (i == 0) ? 8'sd2 : 8'sd9;
    end
    n_chk++;
    if (n_done < 5 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL auto_count: done pulses=%0d busy=%b want >=5 and 0", n_done, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    do_reset();
    test_pos5();
    test_neg3();
    test_zero_then_one();
    test_extremes();
    test_ignore_busy();
    test_reset_mid();
    test_random();
`ifdef TOF_GEN_AUTO_EN
    do_reset();
    test_auto();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tof_edge_gen.md
Name: tof_edge_gen

Overview:
- Stimulus and transmit counterpart of the TOF counter in the estimator path.
- Takes a signed 8-bit time-of-flight target and drives one toggle on each of Y1 and Y2, spaced by |target| clk cycles.
  - Y1 leads for a positive target; Y2 leads for a negative target.
- Used as an on-chip self-test source and as a loopback driver for the TOF counter.
- Outputs are registered and glitch-free, so they can feed the counter's synchronised Y1/Y2 inputs directly.

Parameters:
- GAP, 4: idle cycles after the lagging toggle before the generator is ready again (minimum 1).
- CW, 8: width of the target and of the internal delay counter.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset_L  input  1  asynchronous, active-low reset.
- tof_in  input  CW  signed target delay, two's complement.
- tof_load  input  1  launch strobe; sampled only when busy=0.
- Y1  output  1  generated edge line 1, registered.
- Y2  output  1  generated edge line 2, registered.
- busy  output  1  high from launch acceptance until done.
- done  output  1  one-cycle pulse at the end of the gap.
- tof_last  output  CW  last accepted target, registered.

Behaviour:
- Reset values: Y1=0, Y2=0, busy=0, done=0, tof_last=0, state=IDLE, delay counter=0.
- Reset mid-operation aborts immediately: Y1/Y2 return to 0 and no done pulse is issued.
- Magnitude d=|tof_in|, computed as a CW-bit unsigned value.
  - -128 gives d=128; no saturation.
  - tof_in=0 gives d=0.
- Lead selection:
  - tof_in>0: Y1 leads.
  - tof_in<0: Y2 leads.
  - tof_in=0: Y1 and Y2 toggle on the same edge.
- States:
  - IDLE: on tof_load=1, capture tof_in into tof_last and capture d and the lead select. Set busy=1 and go to LEAD.
  - LEAD: toggle the lead output. If d=0, toggle both outputs and go to GAP. Otherwise load the counter with d-1 and go to DELAY.
  - DELAY: decrement each cycle. When the counter reaches 0, toggle the lag output and go to GAP with the counter loaded to GAP-1.
  - GAP: decrement. When the counter reaches 0, pulse done=1, set busy=0 and go to IDLE.
- Timing, with tof_load sampled at edge k:
  - busy rises at edge k.
  - Lead toggle at edge k+2.
  - Lag toggle at edge k+2+d.
  - done=1 and busy=0 at edge k+2+d+GAP.
- The toggle spacing of exactly d cycles makes the TOF counter report tof_count = +d (Y1 lead) or -d (Y2 lead), up to its saturation at +127/-128.
- tof_load while busy=1 is ignored: no capture, no effect.
- tof_load in the cycle done=1 is accepted, since busy=0 in that cycle.
- Outputs toggle relative to their current level; no return-to-zero.
  - Alternate launches therefore produce alternating rising and falling edges.
- Y1/Y2 change only on the LEAD and DELAY-expiry edges; otherwise they hold.

Optional Feature:
- Macro: TOF_GEN_AUTO_EN.
- Defined:
  - Adds input port auto_en (1 bit).
  - In GAP expiry, if auto_en=1, done still pulses but busy stays 1. The FSM goes directly to LEAD, relaunching with the stored d and lead select without tof_load.
  - The period is therefore d+GAP+1 cycles, and each pass pulses done once.
  - Deasserting auto_en ends the sequence at the next GAP expiry, with normal return to IDLE.
  - tof_load is ignored while busy.
- Undefined:
  - No auto_en port.
  - Single-shot only, exactly as described above.

Test Plan:
- Reset, then tof_in=+5 with tof_load at edge 10: Y1 0→1 at edge 12, Y2 0→1 at edge 17, done at edge 21 (GAP=4), busy high for edges 10..20, tof_last=+5.
- tof_in=-3: Y2 toggles first, Y1 toggles 3 cycles later. Feeding Y1/Y2 into the TOF counter gives tof_count=-3 with tof_ready asserted.
- tof_in=0: Y1 and Y2 toggle on the same edge; done arrives GAP cycles later. A second launch of +1 then drives both lines back to 0, Y1 one cycle before Y2.
- tof_in=-128: lag toggle 128 cycles after the lead. tof_in=+127: lag toggle 127 cycles after the lead. Neither case shows a wrap.
- tof_load pulses during DELAY with tof_in=+9 during a +20 launch: these are ignored and tof_last stays +20. A load in the done cycle is accepted.
- reset_L pulsed low during DELAY: Y1=Y2=0, busy=0, no done. With TOF_GEN_AUTO_EN, auto_en=1 and +2: repeated toggles with period 7 cycles, and done pulses each period.
